// File: rtl/sw_pkg.sv
// sw_pkg: shared base encoding, complement helper and feeder state type
package sw_pkg;
  localparam int BASE_W = 2;
  typedef enum logic [BASE_W-1:0] {BASE_A, BASE_C, BASE_G, BASE_T} base_t;
  typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_SHIFT, ST_GAP, ST_STREAM, ST_DRAIN} feeder_state_t;
  function automatic logic [BASE_W-1:0] sw_base_comp(input logic [BASE_W-1:0] b);
    return b ^ BASE_T;
  endfunction
endpackage

// File: rtl/sw_array_feeder_if.sv
// sw_array_feeder_if: short-read and reference valid/ready streams into the feeder
interface sw_array_feeder_if;
  import sw_pkg::*;
  logic [BASE_W-1:0] read_base;
  logic read_valid;
  logic read_last;
  logic read_ready;
  logic [BASE_W-1:0] ref_base;
  logic ref_valid;
  logic ref_last;
  logic ref_ready;
  modport master (output read_base, read_valid, read_last, ref_base, ref_valid, ref_last,
                  input read_ready, ref_ready);
  modport slave (input read_base, read_valid, read_last, ref_base, ref_valid, ref_last,
                 output read_ready, ref_ready);
endinterface

// File: rtl/sw_read_buf.sv
// sw_read_buf: short-read slot register file, one write port and one async read port
module sw_read_buf
  import sw_pkg::*;
#(
  parameter int NUM_PE = 8,
  localparam int AW = NUM_PE > 1 ? $clog2(NUM_PE) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [BASE_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [BASE_W-1:0] rd_data
);
  logic [BASE_W-1:0] mem [1 << AW];
  always_ff @(posedge clk or negedge rst)
    if (!rst) mem <= '{default: '0};
    else if (wr_en) mem[wr_addr] <= wr_data;
  assign rd_data = mem[rd_addr];
endmodule

// File: rtl/sw_array_feeder.sv
// sw_array_feeder: loads a short read into the SW PE chain then streams the reference; SW_FEEDER_REVCOMP_EN adds read_rc reverse-complement loading
module sw_array_feeder
  import sw_pkg::*;
#(
  parameter int NUM_PE    = 8,
  parameter int LEN_W     = 16,
  parameter int DRAIN_CYC = NUM_PE + 2
) (
  input  logic              clk,
  input  logic              rst,
  sw_array_feeder_if.slave  up,
`ifdef SW_FEEDER_REVCOMP_EN
  input  logic              read_rc,
`endif
  output logic [BASE_W-1:0] S_out,
  output logic              store_S_out,
  output logic [BASE_W-1:0] T_out,
  output logic              init_out,
  output logic              busy,
  output logic              done,
  output logic              len_err,
  output logic [LEN_W-1:0]  ref_count
);
  localparam int AW = NUM_PE > 1 ? $clog2(NUM_PE) : 1;
  localparam int NW = $clog2(NUM_PE + 1);
  localparam int CW = $clog2((DRAIN_CYC > NUM_PE ? DRAIN_CYC : NUM_PE) + 1);
  feeder_state_t state;
  logic [CW-1:0] cnt;
  logic [NW-1:0] nv, nv_n;
  logic [AW-1:0] idx, k_n, ridx;
  logic [BASE_W-1:0] rd_data, sv, emit, s_nxt;
  logic beat, end_read, rc_n;
  assign up.read_ready = rst && (state == ST_IDLE || state == ST_LOAD);
  assign up.ref_ready = state == ST_STREAM;
  assign beat = up.read_valid && up.read_ready;
`ifdef SW_FEEDER_REVCOMP_EN
  logic rc;
  assign rc_n = state == ST_IDLE ? read_rc : rc;
`else
  assign rc_n = 1'b0;
`endif
  // Slots past the received length read as A; the final beat is bypassed so SHIFT can start next cycle
  always_comb begin
    idx = state == ST_LOAD ? cnt[AW-1:0] : '0;
    end_read = up.read_last || idx == AW'(NUM_PE - 1);
    k_n = state == ST_SHIFT ? cnt[AW-1:0] + AW'(1) : '0;
    nv_n = state == ST_SHIFT ? nv : NW'(idx) + NW'(1);
    ridx = rc_n ? k_n : AW'(NUM_PE - 1) - k_n;
    sv = (beat && idx == ridx) ? up.read_base : rd_data;
    emit = NW'(ridx) < nv_n ? sv : BASE_A;
    s_nxt = rc_n ? sw_base_comp(emit) : emit;
  end
  sw_read_buf #(.NUM_PE(NUM_PE)) u_buf (
    .clk(clk), .rst(rst), .wr_en(beat), .wr_addr(idx), .wr_data(up.read_base),
    .rd_addr(ridx), .rd_data(rd_data)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      cnt <= '0;
      nv <= '0;
      S_out <= '0;
      store_S_out <= 1'b0;
      T_out <= '0;
      init_out <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      len_err <= 1'b0;
      ref_count <= '0;
`ifdef SW_FEEDER_REVCOMP_EN
      rc <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      init_out <= 1'b0;
      case (state)
        ST_IDLE, ST_LOAD: if (beat) begin
          busy <= 1'b1;
          len_err <= end_read && !(up.read_last && idx == AW'(NUM_PE - 1));
`ifdef SW_FEEDER_REVCOMP_EN
          rc <= rc_n;
`endif
          if (end_read) begin
            state <= ST_SHIFT;
            cnt <= '0;
            nv <= nv_n;
            ref_count <= '0;
            store_S_out <= 1'b1;
            S_out <= s_nxt;
          end else begin
            state <= ST_LOAD;
            cnt <= CW'(idx) + CW'(1);
          end
        end
        ST_SHIFT: if (cnt == CW'(NUM_PE - 1)) begin
          state <= ST_GAP;
          store_S_out <= 1'b0;
        end else begin
          cnt <= cnt + CW'(1);
          S_out <= s_nxt;
        end
        ST_GAP: state <= ST_STREAM;
        ST_STREAM: if (up.ref_valid) begin
          T_out <= up.ref_base;
          init_out <= 1'b1;
          ref_count <= ref_count + LEN_W'(ref_count != '1);
          if (up.ref_last) begin
            state <= ST_DRAIN;
            cnt <= '0;
          end
        end
        ST_DRAIN: begin
          cnt <= cnt + CW'(1);
          done <= cnt == CW'(DRAIN_CYC - 1);
          if (cnt == CW'(DRAIN_CYC)) begin
            state <= ST_IDLE;
            busy <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sw_array_feeder.sv
// tb_sw_array_feeder: randomized scoreboard bench for sw_array_feeder with NUM_PE=4
module tb_sw_array_feeder;
  localparam int NUM_PE = 4;
  localparam int LEN_W = 16;
  localparam int DRAIN_CYC = NUM_PE + 2;
  typedef struct {logic [1:0] b; int cyc;} tq_t;
  typedef struct {logic err; int cnt;} sum_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [1:0] S_out, T_out;
  logic store_S_out, init_out, busy, done, len_err;
  logic [LEN_W-1:0] ref_count;
  int checks = 0, errors = 0, cyc = 0;
  logic [1:0] exp_s[$];
  int exp_sc[$];
  tq_t exp_t[$];
  sum_t exp_sum[$];
  logic [1:0] rd_bases[$];
  logic [1:0] rf_bases[$];
  logic cur_err = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  sw_array_feeder_if up();
`ifdef SW_FEEDER_REVCOMP_EN
  logic read_rc = 1'b0;
`endif
  sw_array_feeder #(.NUM_PE(NUM_PE), .LEN_W(LEN_W), .DRAIN_CYC(DRAIN_CYC)) dut (
    .clk(clk), .rst(rst), .up(up),
`ifdef SW_FEEDER_REVCOMP_EN
    .read_rc(read_rc),
`endif
    .S_out(S_out), .store_S_out(store_S_out), .T_out(T_out), .init_out(init_out),
    .busy(busy), .done(done), .len_err(len_err), .ref_count(ref_count)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic bail(input string what);
    checks++;
    errors++;
    $display("FAIL timeout %s: no handshake within 300 cycles (cycle %0d)", what, cyc);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask
  task automatic wait_hs(input bit is_ref);
    int t = 0;
    #1;
    while (!(is_ref ? up.ref_ready : up.read_ready)) begin
      if (++t > 300) bail(is_ref ? "ref_ready" : "read_ready");
      @(negedge clk);
      #1;
    end
  endtask
  // Sends rd_bases[0..n-1]; with_last=0 and n=NUM_PE is the overlong-read case
  task automatic send_read(input int n, input bit with_last, input bit rc);
    logic [1:0] slot[NUM_PE];
    bit rc_eff;
`ifdef SW_FEEDER_REVCOMP_EN
    rc_eff = rc;
`else
    rc_eff = 1'b0;
`endif
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == 1) chk("len_err_clear", len_err, 0);
      up.read_valid = 1'b1;
      up.read_base = rd_bases[i];
      up.read_last = with_last && i == n - 1;
`ifdef SW_FEEDER_REVCOMP_EN
      read_rc = i == 0 ? rc : 1'($urandom);
`endif
      wait_hs(1'b0);
    end
    cur_err = !(with_last && n == NUM_PE);
    for (int k = 0; k < NUM_PE; k++) slot[k] = k < n ? rd_bases[k] : 2'b00;
    exp_sc.push_back(cyc + 1);
    for (int k = 0; k < NUM_PE; k++) exp_s.push_back(rc_eff ? slot[k] ^ 2'b11 : slot[NUM_PE-1-k]);
    @(posedge clk);
    #1;
    if (!with_last) begin
      up.read_base = 2'($urandom);
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        chk("ready_after_full", up.read_ready, 0);
      end
    end
    up.read_valid = 1'b0;
    up.read_last = 1'b0;
  endtask
  task automatic send_ref(input int m, input bit with_last, input int gap_pct, input int gap_at);
    for (int i = 0; i < m; i++) begin
      @(negedge clk);
      if (i == gap_at) begin
        up.ref_valid = 1'b0;
        repeat (2) @(negedge clk);
      end
      while (int'($urandom_range(0, 99)) < gap_pct) begin
        up.ref_valid = 1'b0;
        @(negedge clk);
      end
      up.ref_valid = 1'b1;
      up.ref_base = rf_bases[i];
      up.ref_last = with_last && i == m - 1;
      wait_hs(1'b1);
      exp_t.push_back('{rf_bases[i], cyc + 1});
    end
    if (with_last) exp_sum.push_back('{cur_err, m});
    @(posedge clk);
    #1;
    up.ref_valid = 1'b0;
    up.ref_last = 1'b0;
  endtask
  task automatic rand_ref(input int m);
    rf_bases.delete();
    for (int i = 0; i < m; i++) rf_bases.push_back(2'($urandom));
  endtask
  task automatic check_zero(input string tag);
    chk({tag, "_S_out"}, S_out, 0);
    chk({tag, "_store_S"}, store_S_out, 0);
    chk({tag, "_T_out"}, T_out, 0);
    chk({tag, "_init"}, init_out, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_len_err"}, len_err, 0);
    chk({tag, "_ref_count"}, ref_count, 0);
    chk({tag, "_read_ready"}, up.read_ready, 0);
    chk({tag, "_ref_ready"}, up.ref_ready, 0);
  endtask
  logic prev_store = 1'b0, was_done = 1'b0;
  logic [1:0] last_t = 2'b00;
  int last_init_cyc = 0;
  tq_t te;
  sum_t se;
  always @(negedge clk) begin
    if (!rst) begin
      prev_store <= 1'b0;
      was_done <= 1'b0;
      last_t <= 2'b00;
    end else begin
      if (store_S_out) begin
        if (!prev_store) begin
          if (exp_sc.size() == 0) chk("shift_unexpected", 1, 0);
          else chk("shift_start_cycle", cyc, exp_sc.pop_front());
        end
        if (exp_s.size() == 0) chk("S_unexpected", 1, 0);
        else chk("S_out", S_out, exp_s.pop_front());
      end
      prev_store <= store_S_out;
      if (init_out) begin
        if (exp_t.size() == 0) chk("T_unexpected", 1, 0);
        else begin
          te = exp_t.pop_front();
          chk("T_out", T_out, te.b);
          chk("T_cycle", cyc, te.cyc);
          last_t <= te.b;
        end
        last_init_cyc <= cyc;
      end else chk("T_hold", T_out, last_t);
      if (done) begin
        if (exp_sum.size() == 0) chk("done_unexpected", 1, 0);
        else begin
          se = exp_sum.pop_front();
          chk("len_err", len_err, se.err);
          chk("ref_count", ref_count, se.cnt);
          chk("drain_len", cyc - last_init_cyc, DRAIN_CYC);
          chk("busy_at_done", busy, 1);
        end
      end
      if (was_done) chk("busy_after_done", busy, 0);
      was_done <= done;
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000 time units");
    $fatal(1, "watchdog");
  end
  initial begin
    int n, m, r;
    up.read_valid = 1'b0;
    up.read_last = 1'b0;
    up.read_base = 2'b00;
    up.ref_valid = 1'b0;
    up.ref_last = 1'b0;
    up.ref_base = 2'b00;
    repeat (2) @(negedge clk);
    #1;
    check_zero("reset");
    #1;
    rst = 1'b1;
    #1;
    chk("ready_after_reset", up.read_ready, 1);
    rd_bases = '{2'b00, 2'b01, 2'b10, 2'b11};
    send_read(4, 1'b1, 1'b0);
    rf_bases = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b11, 2'b00};
    send_ref(8, 1'b1, 0, -1);
    rd_bases = '{2'b10, 2'b11, 2'b01, 2'b00};
    send_read(4, 1'b1, 1'b0);
    rand_ref(7);
    send_ref(7, 1'b1, 0, 3);
    rd_bases = '{2'b01, 2'b11};
    send_read(2, 1'b1, 1'b0);
    rand_ref(3);
    send_ref(3, 1'b1, 0, -1);
    rd_bases = '{2'b00, 2'b01, 2'b10, 2'b11};
    send_read(4, 1'b1, 1'b1);
    rand_ref(4);
    send_ref(4, 1'b1, 20, -1);
    rd_bases = '{2'b11, 2'b10, 2'b00, 2'b01};
    send_read(4, 1'b1, 1'b0);
    rand_ref(5);
    send_ref(3, 1'b0, 0, -1);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_zero("async_reset");
    exp_s.delete();
    exp_sc.delete();
    exp_t.delete();
    exp_sum.delete();
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("idle_read_ready", up.read_ready, 1);
    chk("idle_busy", busy, 0);
    for (int it = 0; it < 14; it++) begin
      r = $urandom_range(0, 9);
      n = r < 6 ? NUM_PE : (r < 8 ? int'($urandom_range(1, NUM_PE - 1)) : NUM_PE);
      rd_bases.delete();
      for (int i = 0; i < n; i++) rd_bases.push_back(2'($urandom));
      send_read(n, r < 8, 1'($urandom));
      m = $urandom_range(1, 10);
      rand_ref(m);
      send_ref(m, 1'b1, 30, -1);
    end
    begin
      int t = 0;
      while ((busy || exp_t.size() != 0 || exp_s.size() != 0 || exp_sum.size() != 0) && t < 500) begin
        @(negedge clk);
        t++;
      end
    end
    @(negedge clk);
    chk("scoreboard_empty", exp_t.size() + exp_s.size() + exp_sum.size() + exp_sc.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
